program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/rv_loader_pkg.sv | 17 +
 rtl/word_assembler.sv | 36 +++
 rtl/program_loader.sv | 133 +++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_loader_pkg.sv
// rtl/rv_loader_pkg.sv - shared state type and constants for the program loader
package rv_loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         IM_ADDR_W     = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word packer with running payload XOR
module word_assembler (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_last,
  output logic [7:0]  xor_sum
);

  logic [23:0] lo_bytes;
  logic [1:0]  lane;

  // The completing byte is combined combinationally so the word is ready on the byte-3 edge.
  assign word      = {byte_in, lo_bytes};
  assign word_last = byte_en && (lane == 2'd3);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      lo_bytes <= '0;
      lane     <= '0;
      xor_sum  <= '0;
    end else if (clear) begin
      lo_bytes <= '0;
      lane     <= '0;
      xor_sum  <= '0;
    end else if (byte_en) begin
      lo_bytes <= {byte_in, lo_bytes[23:8]};
      lane     <= lane + 2'd1;
      xor_sum  <= xor_sum ^ byte_in;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader into instruction memory, holds the CPU in reset until verified
module program_loader
  import rv_loader_pkg::*;
#(
  parameter int         MAX_WORDS = 64,
  parameter int         TIMEOUT   = 1000,
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wd,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic                 error
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [16:0]      MAX_N    = 17'(MAX_WORDS);

  state_t           state;
  logic [7:0]       len_lo;
  logic [15:0]      n_words;
  logic [15:0]      word_idx;
  logic [TMO_W-1:0] tmo_cnt;

  logic        accept;
  logic        in_frame;
  logic        tmo_hit;
  logic        asm_clear;
  logic        asm_en;
  logic        word_last;
  logic [31:0] asm_word;
  logic [7:0]  xor_sum;
  logic [15:0] len_full;

  assign rx_ready  = (state != S_DONE) && (state != S_ERR);
  assign accept    = rx_valid && rx_ready;
  assign in_frame  = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  assign tmo_hit   = in_frame && !accept && (tmo_cnt == TMO_LAST);
  assign asm_clear = accept && (state == S_IDLE) && (rx_data == MAGIC);
  assign asm_en    = accept && (state == S_DATA);
  assign len_full  = {rx_data, len_lo};

  word_assembler u_word_assembler (
    .clk       (clk),
    .a_rst     (a_rst),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_last (word_last),
    .xor_sum   (xor_sum)
  );

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state     <= S_IDLE;
      len_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      tmo_cnt   <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wd     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      im_we <= 1'b0;

      if (in_frame && !accept) tmo_cnt <= tmo_cnt + 1'b1;
      else                     tmo_cnt <= '0;

      // An idle stall wins over everything else once the budget is used up.
      if (tmo_hit) begin
        state <= S_ERR;
        error <= 1'b1;
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            if (rx_data == MAGIC) begin
              state    <= S_LEN_LO;
              word_idx <= '0;
            end
          end
          S_LEN_LO: begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            n_words <= len_full;
            if (len_full == 16'd0) begin
              state <= S_CSUM;
            end else if ({1'b0, len_full} > MAX_N) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (word_last) begin
              im_we    <= 1'b1;
              im_addr  <= IM_ADDR_W'(word_idx);
              im_wd    <= asm_word;
              word_idx <= word_idx + 16'd1;
              if (word_idx == n_words - 16'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_data == xor_sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized frame stimulus checked against a frame-parsing reference model
module tb_program_loader;

  localparam int         MAX_WORDS = 64;
  localparam int         TIMEOUT   = 1000;
  localparam logic [7:0] MAGIC     = 8'hA5;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        im_we;
  logic [29:0] im_addr;
  logic [31:0] im_wd;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_bytes[$];
  int          tx_gaps[$];
  logic [31:0] pay_words[$];
  logic [61:0] exp_wr[$];
  logic [61:0] cap_wr[$];
  int          exp_status;
  int          exp_consumed;
  bit          exp_tmo;
  int          tmo_gap;

  always #5 clk = ~clk;

  program_loader #(
    .MAX_WORDS (MAX_WORDS),
    .TIMEOUT   (TIMEOUT),
    .MAGIC     (MAGIC)
  ) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wd     (im_wd),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .error     (error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rst) begin
      if (im_we) cap_wr.push_back({im_addr, im_wd});
      check_eq("cpu_rst_n_vs_done", cpu_rst_n, done);
    end
  end

  task automatic add_byte(input logic [7:0] b, input int gap);
    tx_bytes.push_back(b);
    tx_gaps.push_back(gap);
  endtask

  // Frame from pay_words; n is the advertised length, which may disagree with the payload.
  task automatic add_frame(input int n, input bit bad_csum, input int maxgap);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    add_byte(MAGIC, $urandom_range(0, maxgap));
    add_byte(n[7:0], $urandom_range(0, maxgap));
    add_byte(n[15:8], $urandom_range(0, maxgap));
    foreach (pay_words[i]) begin
      w = pay_words[i];
      for (int k = 0; k < 4; k++) begin
        add_byte(w[8*k +: 8], $urandom_range(0, maxgap));
        cs = cs ^ w[8*k +: 8];
      end
    end
    add_byte(bad_csum ? cs + 8'd1 : cs, $urandom_range(0, maxgap));
  endtask

  task automatic model();
    int          phase;
    int          n;
    int          k;
    int          widx;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    phase = 0; n = 0; k = 0; widx = 0; x = 8'h00; w = '0;
    exp_wr.delete();
    exp_status = 0; exp_consumed = 0; exp_tmo = 1'b0; tmo_gap = 0;
    foreach (tx_bytes[i]) begin
      if (phase != 0 && tx_gaps[i] >= TIMEOUT) begin
        exp_status = 2; exp_tmo = 1'b1; tmo_gap = tx_gaps[i];
        break;
      end
      exp_consumed = i + 1;
      b = tx_bytes[i];
      if (phase == 0) begin
        if (b == MAGIC) begin phase = 1; x = 8'h00; k = 0; widx = 0; end
      end else if (phase == 1) begin
        n = int'(b); phase = 2;
      end else if (phase == 2) begin
        n = n + 256 * int'(b);
        if (n == 0) phase = 4;
        else if (n > MAX_WORDS) begin exp_status = 2; break; end
        else phase = 3;
      end else if (phase == 3) begin
        w[8*k +: 8] = b;
        x = x ^ b;
        k++;
        if (k == 4) begin
          exp_wr.push_back({widx[29:0], w});
          widx++; k = 0;
          if (widx == n) phase = 4;
        end
      end else begin
        exp_status = (b == x) ? 1 : 2;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    a_rst = 1'b0;
    #1;
    check_eq("rst_rx_ready", rx_ready, 1'b1);
    check_eq("rst_im_we", im_we, 1'b0);
    check_eq("rst_im_addr", im_addr, 30'd0);
    check_eq("rst_im_wd", im_wd, 32'd0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_case(input string name);
    model();
    cap_wr.delete();
    for (int i = 0; i < exp_consumed; i++) begin
      rx_valid = 1'b0;
      repeat (tx_gaps[i]) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = tx_bytes[i];
      check_eq({name, "_ready"}, rx_ready, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    if (exp_tmo) repeat (tmo_gap) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    check_eq({name, "_nwr"}, cap_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < cap_wr.size(); i++) begin
      check_eq({name, "_addr"}, cap_wr[i][61:32], exp_wr[i][61:32]);
      check_eq({name, "_data"}, cap_wr[i][31:0], exp_wr[i][31:0]);
    end
    check_eq({name, "_done"}, done, exp_status == 1);
    check_eq({name, "_error"}, error, exp_status == 2);
    check_eq({name, "_cpu_rst_n"}, cpu_rst_n, exp_status == 1);
    check_eq({name, "_rx_ready"}, rx_ready, exp_status == 0);
    tx_bytes.delete();
    tx_gaps.delete();
    pay_words.delete();
  endtask

  initial begin
    logic [7:0] seq[$];
    int n;
    int npre;
    int j;

    apply_reset();
    pay_words = '{32'h0000_0013, 32'h0010_0093};
    add_frame(2, 1'b0, 0);
    run_case("two_words");

    apply_reset();
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    foreach (seq[i]) add_byte(seq[i], 0);
    run_case("lead_junk");

    apply_reset();
    seq = '{8'hA5, 8'h41, 8'h00};
    foreach (seq[i]) add_byte(seq[i], 1);
    run_case("too_long");

    apply_reset();
    pay_words = '{32'hDEAD_BEEF};
    add_frame(1, 1'b1, 1);
    run_case("bad_csum");

    apply_reset();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    foreach (seq[i]) add_byte(seq[i], (i == 6) ? TIMEOUT : 0);
    run_case("stall");
    apply_reset();
    pay_words = '{32'h1111_2222, 32'h3333_4444};
    add_frame(2, 1'b0, 0);
    run_case("after_stall");

    apply_reset();
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    foreach (seq[i]) add_byte(seq[i], 0);
    run_case("empty");

    apply_reset();
    pay_words = '{32'hCAFE_F00D};
    add_frame(1, 1'b0, 0);
    tx_gaps[5] = TIMEOUT - 1;
    run_case("stall_edge");

    apply_reset();
    pay_words = '{32'hA1A2_A3A4, 32'hB1B2_B3B4};
    add_frame(3, 1'b0, 0);
    void'(tx_bytes.pop_back());
    void'(tx_gaps.pop_back());
    add_byte(8'h5A, 0);
    run_case("partial");
    check_eq("partial_addr_held", im_addr, 30'd1);
    apply_reset();
    pay_words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C};
    add_frame(3, 1'b0, 2);
    run_case("restart");

    for (int t = 0; t < 24; t++) begin
      apply_reset();
      npre = $urandom_range(0, 2);
      for (int i = 0; i < npre; i++) begin
        seq = '{8'h00};
        seq[0] = 8'($urandom);
        if (seq[0] == MAGIC) seq[0] = 8'h3C;
        add_byte(seq[0], $urandom_range(0, 3));
      end
      n = ($urandom_range(0, 7) == 0) ? MAX_WORDS + $urandom_range(0, 1) : $urandom_range(0, 5);
      for (int i = 0; i < n; i++) pay_words.push_back($urandom);
      add_frame(n, $urandom_range(0, 4) == 0, 2);
      if ($urandom_range(0, 5) == 0) begin
        j = npre + 1 + $urandom_range(0, tx_bytes.size() - npre - 2);
        tx_gaps[j] = TIMEOUT - 1 + $urandom_range(0, 1);
      end
      run_case("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
